alu_op_arbiter: RTL and testbench

- Shares one registered ALU between two requesters (REQ0, REQ1).
- The ALU has 1-cycle latency: EN, ALU_FUN, A and B in, registered ALU_OUT and OUT_VALID out.
- The block arbitrates round-robin, issues exactly one ALU operation at a time, waits for OUT_VALID with a timeout guard, and returns the result on a valid/ready response channel tagged with the requester ID.
- It sits between the command front-ends and the ALU instance in the system top.

---
 rtl/alu_op_arbiter_pkg.sv | 22 ++
 rtl/alu_op_arbiter_rr_arb2.sv | 25 ++
 rtl/alu_op_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_op_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_arbiter_pkg.sv
// Shared constants for the ALU operation arbiter: FSM encoding, ALU function codes, requester IDs.
package alu_op_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam logic [3:0] FUN_ADD = 4'b0000;
  localparam logic [3:0] FUN_SUB = 4'b0001;
  localparam logic [3:0] FUN_MUL = 4'b0010;
  localparam logic [3:0] FUN_DIV = 4'b0011;
  localparam logic [3:0] FUN_AND = 4'b0100;
  localparam logic [3:0] FUN_OR  = 4'b0101;
  localparam logic [3:0] FUN_XOR = 4'b0110;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/alu_op_arbiter_rr_arb2.sv
// Two-way round-robin picker; the last-grant register lives in the parent.
module rr_arb2
  import alu_op_arbiter_pkg::*;
(
  input  logic [1:0] VALID,
  input  logic       LAST_GNT,
  output logic [1:0] GNT,
  output logic       GNT_ID
);

  // Single requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    GNT_ID = ID_REQ0;
    if (VALID == 2'b11) begin
      GNT_ID = ~LAST_GNT;
    end else if (VALID[1]) begin
      GNT_ID = ID_REQ1;
    end
    GNT = 2'b00;
    if (|VALID) begin
      GNT = GNT_ID ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one 1-cycle registered ALU between two requesters; one operation in flight,
// timeout-guarded, result returned on a tagged valid/ready response channel.
module alu_op_arbiter
  import alu_op_arbiter_pkg::*;
#(
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [3:0]            REQ0_FUN,
  input  logic [OPER_WIDTH-1:0] REQ0_A,
  input  logic [OPER_WIDTH-1:0] REQ0_B,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [3:0]            REQ1_FUN,
  input  logic [OPER_WIDTH-1:0] REQ1_A,
  input  logic [OPER_WIDTH-1:0] REQ1_B,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_ID,
  output logic [OUT_WIDTH-1:0]  RSP_DATA,
  output logic                  RSP_ERR
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  state_t                  state, state_nxt;
  logic [TMR_W-1:0]        timer, timer_nxt;
  logic                    last_gnt, last_gnt_nxt;
  logic                    op_id, op_id_nxt;
  logic [1:0]              gnt;
  logic                    gnt_id;
  logic [3:0]              sel_fun;
  logic [OPER_WIDTH-1:0]   sel_a, sel_b;
  logic                    alu_en_nxt;
  logic [3:0]              alu_fun_nxt;
  logic [OPER_WIDTH-1:0]   alu_a_nxt, alu_b_nxt;
  logic                    rsp_valid_nxt, rsp_id_nxt, rsp_err_nxt;
  logic [OUT_WIDTH-1:0]    rsp_data_nxt;

  rr_arb2 u_arb (
    .VALID    ({REQ1_VALID, REQ0_VALID}),
    .LAST_GNT (last_gnt),
    .GNT      (gnt),
    .GNT_ID   (gnt_id)
  );

  // Accept handshake is combinational and only open in IDLE.
  assign REQ0_READY = (state == ST_IDLE) && gnt[0];
  assign REQ1_READY = (state == ST_IDLE) && gnt[1];

  assign sel_fun = gnt_id ? REQ1_FUN : REQ0_FUN;
  assign sel_a   = gnt_id ? REQ1_A   : REQ0_A;
  assign sel_b   = gnt_id ? REQ1_B   : REQ0_B;

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      timer     <= '0;
      last_gnt  <= ID_REQ1;
      op_id     <= ID_REQ0;
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= ID_REQ0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      last_gnt  <= last_gnt_nxt;
      op_id     <= op_id_nxt;
      ALU_EN    <= alu_en_nxt;
      ALU_FUN   <= alu_fun_nxt;
      ALU_A     <= alu_a_nxt;
      ALU_B     <= alu_b_nxt;
      RSP_VALID <= rsp_valid_nxt;
      RSP_ID    <= rsp_id_nxt;
      RSP_DATA  <= rsp_data_nxt;
      RSP_ERR   <= rsp_err_nxt;
    end
  end

  // Next-state and next-output logic. The ALU operand registers double as the
  // op registers: they are loaded on accept so ALU_EN is high exactly in ISSUE.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    last_gnt_nxt  = last_gnt;
    op_id_nxt     = op_id;
    alu_en_nxt    = 1'b0;
    alu_fun_nxt   = ALU_FUN;
    alu_a_nxt     = ALU_A;
    alu_b_nxt     = ALU_B;
    rsp_valid_nxt = RSP_VALID;
    rsp_id_nxt    = RSP_ID;
    rsp_data_nxt  = RSP_DATA;
    rsp_err_nxt   = RSP_ERR;
    case (state)
      ST_IDLE: begin
        if (|gnt) begin
          last_gnt_nxt = gnt_id;
          op_id_nxt    = gnt_id;
          if ((sel_fun == FUN_DIV) && (sel_b == '0)) begin
            // Divide-by-zero is answered directly without touching the ALU.
            state_nxt     = ST_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = gnt_id;
            rsp_data_nxt  = '0;
            rsp_err_nxt   = 1'b1;
          end else begin
            state_nxt   = ST_ISSUE;
            alu_en_nxt  = 1'b1;
            alu_fun_nxt = sel_fun;
            alu_a_nxt   = sel_a;
            alu_b_nxt   = sel_b;
          end
        end
      end
      ST_ISSUE: begin
        timer_nxt = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (ALU_OUT_VALID) begin
          state_nxt     = ST_RESP;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = op_id;
          rsp_data_nxt  = ALU_OUT;
          rsp_err_nxt   = 1'b0;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nxt     = ST_RESP;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = op_id;
          rsp_data_nxt  = '0;
          rsp_err_nxt   = 1'b1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Scoreboard bench for alu_op_arbiter with a behavioural 1-cycle ALU.
module tb_alu_op_arbiter;
  import alu_op_arbiter_pkg::*;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic       CLK, RST;
  logic       REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [3:0] REQ0_FUN, REQ1_FUN;
  logic [7:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic [7:0] ALU_A, ALU_B;
  logic [7:0] alu_out;
  logic       alu_vld;
  logic       RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [7:0] RSP_DATA;

  logic       alu_stall;
  logic       en_seen;
  rsp_t       exp_q[$];
  rsp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;

  alu_op_arbiter #(.OPER_WIDTH(8), .OUT_WIDTH(8), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_FUN(REQ0_FUN), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_FUN(REQ1_FUN), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_vld),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (f)
      FUN_ADD: return a + b;
      FUN_SUB: return a - b;
      FUN_MUL: return p[7:0];
      FUN_DIV: return (b == 8'd0) ? 8'd0 : a / b;
      FUN_AND: return a & b;
      FUN_OR:  return a | b;
      FUN_XOR: return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  // Behavioural ALU: result and valid one cycle after ALU_EN; alu_stall suppresses valid.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_out <= 8'd0;
      alu_vld <= 1'b0;
    end else begin
      alu_vld <= ALU_EN && !alu_stall;
      if (ALU_EN) alu_out <= alu_calc(ALU_FUN, ALU_A, ALU_B);
    end
  end

  always @(negedge CLK) if (ALU_EN) en_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every completed response transfer is matched against the scoreboard.
  always @(negedge CLK) begin
    if (!RST && RSP_VALID && RSP_READY) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: actual id=%0d data=%0h err=%0d required no response", RSP_ID, RSP_DATA, RSP_ERR);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id_data_err", 32'({RSP_ID, RSP_DATA, RSP_ERR}), 32'({mon_e.id, mon_e.data, mon_e.err}));
      end
    end
  end

  task automatic drive_req(input bit idx, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    if (idx) begin
      REQ1_FUN = f; REQ1_A = a; REQ1_B = b; REQ1_VALID = 1'b1;
    end else begin
      REQ0_FUN = f; REQ0_A = a; REQ0_B = b; REQ0_VALID = 1'b1;
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [7:0] data, input logic err);
    rsp_t e;
    e.id = id; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  // Waits for the handshake of one requester, then drops its VALID after the accept edge.
  task automatic wait_accept(input bit idx, input int budget, output int cycles, output logic other_rdy);
    bit got;
    got = 1'b0; cycles = 0; other_rdy = 1'b0;
    while (!got && cycles < budget) begin
      @(negedge CLK);
      cycles++;
      if (!idx && REQ0_VALID && REQ0_READY) begin
        got = 1'b1; other_rdy = REQ1_READY;
      end else if (idx && REQ1_VALID && REQ1_READY) begin
        got = 1'b1; other_rdy = REQ0_READY;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_req%0d: actual no accept in %0d cycles required accept", idx, budget);
    end
    @(posedge CLK); #1;
    if (idx) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      @(negedge CLK);
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: actual %0d responses outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cyc;
    logic       oth;
    logic [8:0] held;

    RST = 1'b1; alu_stall = 1'b0; en_seen = 1'b0; RSP_READY = 1'b1;
    REQ0_VALID = 1'b0; REQ0_FUN = 4'd0; REQ0_A = 8'd0; REQ0_B = 8'd0;
    REQ1_VALID = 1'b0; REQ1_FUN = 4'd0; REQ1_A = 8'd0; REQ1_B = 8'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", 32'({ALU_EN, ALU_FUN, ALU_A, ALU_B, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR}), 32'd0);
    check("reset_ready", 32'({REQ1_READY, REQ0_READY}), 32'd0);
    tick();
    RST = 1'b0;

    // 1: single ADD, nominal latency
    drive_req(0, FUN_ADD, 8'h12, 8'h34);
    expect_rsp(ID_REQ0, 8'h46, 1'b0);
    wait_accept(0, 10, cyc, oth);
    check("t1_accept_cycle", 32'(cyc), 32'd1);
    @(negedge CLK);
    check("t1_en_n1", 32'({ALU_EN, ALU_FUN, ALU_A, ALU_B}), 32'({1'b1, FUN_ADD, 8'h12, 8'h34}));
    @(negedge CLK);
    check("t1_en_n2", 32'({ALU_EN, RSP_VALID}), 32'd0);
    @(negedge CLK);
    check("t1_rsp_n3", 32'(RSP_VALID), 32'd1);
    drain("t1");

    // 2: tie from reset, REQ0 first, then next tie back to REQ0
    RST = 1'b1;
    drive_req(0, FUN_SUB, 8'h09, 8'h03);
    drive_req(1, FUN_MUL, 8'h03, 8'h05);
    expect_rsp(ID_REQ0, 8'h06, 1'b0);
    expect_rsp(ID_REQ1, 8'h0F, 1'b0);
    tick(); tick();
    RST = 1'b0;
    wait_accept(0, 10, cyc, oth);
    check("t2_tie_req0", 32'({cyc[3:0], oth}), 32'({4'd1, 1'b0}));
    wait_accept(1, 20, cyc, oth);
    drain("t2a");
    drive_req(0, FUN_ADD, 8'h01, 8'h02);
    drive_req(1, FUN_AND, 8'hFF, 8'h3C);
    expect_rsp(ID_REQ0, 8'h03, 1'b0);
    expect_rsp(ID_REQ1, 8'h3C, 1'b0);
    wait_accept(0, 10, cyc, oth);
    check("t2_next_tie_req0", 32'(oth), 32'd0);
    wait_accept(1, 20, cyc, oth);
    drain("t2b");

    // 3: divide by zero answered without ALU issue
    en_seen = 1'b0;
    drive_req(1, FUN_DIV, 8'h20, 8'h00);
    expect_rsp(ID_REQ1, 8'h00, 1'b1);
    wait_accept(1, 10, cyc, oth);
    @(negedge CLK);
    check("t3_rsp_next_cycle", 32'({RSP_VALID, RSP_ERR}), 32'd3);
    drain("t3");
    check("t3_no_alu_en", 32'(en_seen), 32'd0);

    // 4: timeout after 4 WAIT cycles, then normal service resumes
    alu_stall = 1'b1;
    drive_req(0, FUN_ADD, 8'h05, 8'h05);
    expect_rsp(ID_REQ0, 8'h00, 1'b1);
    wait_accept(0, 10, cyc, oth);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      check($sformatf("t4_rsp_valid_n%0d", i), 32'(RSP_VALID), 32'(i == 6));
    end
    drain("t4");
    alu_stall = 1'b0;
    drive_req(1, FUN_OR, 8'h11, 8'h22);
    expect_rsp(ID_REQ1, 8'h33, 1'b0);
    wait_accept(1, 10, cyc, oth);
    drain("t4b");

    // 5: response back-pressure with REQ1 pending
    RSP_READY = 1'b0;
    drive_req(0, FUN_ADD, 8'h07, 8'h08);
    expect_rsp(ID_REQ0, 8'h0F, 1'b0);
    wait_accept(0, 10, cyc, oth);
    drive_req(1, FUN_SUB, 8'h0A, 8'h03);
    expect_rsp(ID_REQ1, 8'h07, 1'b0);
    cyc = 0;
    while (!RSP_VALID && cyc < 10) begin
      @(negedge CLK);
      cyc++;
    end
    check("t5_rsp_valid", 32'(RSP_VALID), 32'd1);
    held = {RSP_ID, RSP_DATA};
    check("t5_first_hold", 32'({RSP_ID, RSP_DATA, RSP_ERR, REQ1_READY}), 32'({1'b0, 8'h0F, 1'b0, 1'b0}));
    for (int i = 2; i <= 5; i++) begin
      @(negedge CLK);
      check($sformatf("t5_hold_c%0d", i), 32'({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, REQ1_READY}),
            32'({1'b1, held, 1'b0, 1'b0}));
    end
    tick();
    RSP_READY = 1'b1;
    @(negedge CLK);
    wait_accept(1, 10, cyc, oth);
    check("t5_req1_next_cycle", 32'(cyc), 32'd1);
    drain("t5");

    // 6: reset during WAIT aborts the operation
    alu_stall = 1'b1;
    drive_req(0, FUN_SUB, 8'h55, 8'h11);
    wait_accept(0, 10, cyc, oth);
    @(negedge CLK);
    @(negedge CLK);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    check("t6_reset_outputs", 32'({ALU_EN, ALU_FUN, ALU_A, ALU_B, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR}), 32'd0);
    tick();
    alu_stall = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("t6_no_rsp_%0d", i), 32'(RSP_VALID), 32'd0);
    end
    tick();
    drive_req(0, FUN_OR, 8'hF0, 8'h0F);
    expect_rsp(ID_REQ0, 8'hFF, 1'b0);
    wait_accept(0, 10, cyc, oth);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
